rvga_mem_initiator: RTL

- Synthesizable initiator for the rvga memory protocol (r_v / w_v / addr / data / resp_v), i.e. the processor-side counterpart of the test_ddr responder.
- Accepts one load or store at a time from a pipeline stage over valid/ready and drives the memory port until the responder returns resp_v.
- Holds the result until the pipeline consumes it.
- Used for both imem fetch and dmem access in rvga_top.

---
 rtl/rvga_mem_initiator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rvga_mem_initiator.sv
// Single-outstanding load/store initiator for the rvga memory port.
// Define RVGA_MEM_TIMEOUT_EN to abort a REQ that sees no mem_resp_v_i within timeout_p cycles.
module rvga_mem_initiator #(
  parameter int unsigned word_width_p = 32,
  parameter int unsigned timeout_p    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_v_i,
  input  logic                    req_we_i,
  input  logic [word_width_p-1:0] req_addr_i,
  input  logic [word_width_p-1:0] req_data_i,
  output logic                    req_ready_o,
  output logic                    mem_r_v_o,
  output logic                    mem_w_v_o,
  output logic [word_width_p-1:0] mem_addr_o,
  output logic [word_width_p-1:0] mem_data_o,
  input  logic [word_width_p-1:0] mem_data_i,
  input  logic                    mem_resp_v_i,
  output logic                    resp_v_o,
  output logic [word_width_p-1:0] resp_data_o,
  output logic                    resp_err_o,
  input  logic                    resp_yumi_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e                  r_state;
  logic                    r_we;
  logic [word_width_p-1:0] r_addr;
  logic [word_width_p-1:0] r_wdata;
  logic [word_width_p-1:0] r_rdata;
  logic                    r_err;
  logic                    r_ready;
  logic                    r_mem_r_v;
  logic                    r_mem_w_v;
  logic                    r_resp_v;

`ifdef RVGA_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(timeout_p + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_expire;

  assign w_cnt_next = r_cnt + 1'b1;
  // Expiry fires on the edge that would bring the count to timeout_p.
  assign w_expire   = (w_cnt_next == CNT_W'(timeout_p));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_mem_r_v <= 1'b0;
      r_mem_w_v <= 1'b0;
      r_resp_v  <= 1'b0;
`ifdef RVGA_MEM_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_v_i) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_data_i;
            r_rdata <= '0;
            r_ready <= 1'b0;
            if (req_addr_i[1:0] != 2'b00) begin
              r_state  <= DONE;
              r_err    <= 1'b1;
              r_resp_v <= 1'b1;
            end else begin
              r_state   <= REQ;
              r_err     <= 1'b0;
              r_mem_r_v <= ~req_we_i;
              r_mem_w_v <= req_we_i;
`ifdef RVGA_MEM_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end
        REQ: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (mem_resp_v_i) begin
            r_rdata   <= r_we ? '0 : mem_data_i;
            r_mem_r_v <= 1'b0;
            r_mem_w_v <= 1'b0;
            r_resp_v  <= 1'b1;
            r_state   <= DONE;
          end
`ifdef RVGA_MEM_TIMEOUT_EN
          else if (w_expire) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_mem_r_v <= 1'b0;
            r_mem_w_v <= 1'b0;
            r_resp_v  <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
`endif
        end
        DONE: begin
          if (resp_yumi_i) begin
            r_resp_v <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ready   <= 1'b1;
          r_mem_r_v <= 1'b0;
          r_mem_w_v <= 1'b0;
          r_resp_v  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign mem_r_v_o   = r_mem_r_v;
  assign mem_w_v_o   = r_mem_w_v;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_wdata;
  assign resp_v_o    = r_resp_v;
  assign resp_data_o = r_rdata;
  assign resp_err_o  = r_err;

endmodule
